// File: rtl/spike_pkg.sv
// Shared types and default widths for the spike-rate measurement path
// (neuron bench, rate meter and JTAG readout).
package spike_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } meter_state_t;

    localparam int SPIKE_CNT_WIDTH = 16;
    localparam int SPIKE_WIN_WIDTH = 16;

endpackage

// File: rtl/spike_window_timer.sv
// Window down-counter: load wins over enable, counting stops at zero and
// 'last' flags the final cycle of a window.
module spike_window_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             last
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last = (count_q == '0);

endmodule

// File: rtl/spike_rate_meter.sv
// Counts spikes over a programmable window and offers each window's count
// on a registered valid/ready output with sticky overwrite detection.
module spike_rate_meter
    import spike_pkg::*;
#(
    parameter int CNT_WIDTH = SPIKE_CNT_WIDTH,
    parameter int WIN_WIDTH = SPIKE_WIN_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 spike_in,
    input  logic [WIN_WIDTH-1:0] window,
    output logic [CNT_WIDTH-1:0] count_data,
    output logic                 count_sat,
    output logic                 count_valid,
    input  logic                 count_ready,
    output logic                 dropped,
    output meter_state_t         state_dbg
);

    // Handshake: a result is transferred on any rising edge where
    // count_valid & count_ready; count_valid never depends on count_ready
    // combinationally, and a fresh result may load in the transfer cycle.

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    meter_state_t         state_q, state_d;
    logic [CNT_WIDTH-1:0] acc_q, acc_d;
    logic                 sat_q, sat_d;
    logic [CNT_WIDTH-1:0] data_q, data_d;
    logic                 osat_q, osat_d;
    logic                 valid_q, valid_d;
    logic                 dropped_q, dropped_d;

    logic                 timer_load;
    logic [WIN_WIDTH-1:0] timer_val;
    logic                 timer_en;
    logic                 timer_last;

    logic                 win_start;
    logic [CNT_WIDTH-1:0] acc_sum;
    logic                 sat_next;

    assign win_start = enable && (window != '0);
    assign acc_sum   = (acc_q == CNT_MAX) ? CNT_MAX
                                          : acc_q + {{(CNT_WIDTH-1){1'b0}}, spike_in};
    assign sat_next  = sat_q || (acc_sum == CNT_MAX);

    spike_window_timer #(
        .WIDTH (WIN_WIDTH)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .en       (timer_en),
        .last     (timer_last)
    );

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        sat_d      = sat_q;
        data_d     = data_q;
        osat_d     = osat_q;
        valid_d    = valid_q;
        dropped_d  = dropped_q;
        timer_load = 1'b0;
        timer_val  = window - WIN_WIDTH'(1);
        timer_en   = 1'b0;

        if (valid_q && count_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (win_start) begin
                    state_d    = ST_COUNT;
                    timer_load = 1'b1;
                    acc_d      = '0;
                    sat_d      = 1'b0;
                end
            end
            ST_COUNT: begin
                if (timer_last) begin
                    // Window end completes even if enable drops on this cycle.
                    data_d  = acc_sum;
                    osat_d  = sat_next;
                    valid_d = 1'b1;
                    if (valid_q && !count_ready) begin
                        dropped_d = 1'b1;
                    end
                    acc_d = '0;
                    sat_d = 1'b0;
                    if (win_start) begin
                        timer_load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (!enable) begin
                    state_d    = ST_IDLE;
                    acc_d      = '0;
                    sat_d      = 1'b0;
                    timer_load = 1'b1;
                    timer_val  = '0;
                end else begin
                    acc_d    = acc_sum;
                    sat_d    = sat_next;
                    timer_en = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            sat_q     <= 1'b0;
            data_q    <= '0;
            osat_q    <= 1'b0;
            valid_q   <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            sat_q     <= sat_d;
            data_q    <= data_d;
            osat_q    <= osat_d;
            valid_q   <= valid_d;
            dropped_q <= dropped_d;
        end
    end

    assign count_data  = data_q;
    assign count_sat   = osat_q;
    assign count_valid = valid_q;
    assign dropped     = dropped_q;
    assign state_dbg   = state_q;

endmodule
